fwrisc_exec_branch_unit: RTL and testbench

- Responder end of the decode→exec branch interface.
- Accepts a decoded branch (op_type, op_a, op_b, op, op_c) under decode_valid, evaluates the comparison, updates the architectural PC and pulses instr_complete.
- Sits inside the exec stage as the branch/PC-update path.
- Is the DUT counterpart of the formal branch stimulus, so it must satisfy "eventually instr_complete" for every accepted instruction.

---
 rtl/fwrisc_exec_branch_unit_pkg.sv | 24 ++
 rtl/fwrisc_exec_branch_unit_if.sv | 26 ++
 rtl/fwrisc_branch_cond.sv | 28 ++
 rtl/fwrisc_exec_branch_unit.sv | 110 +++++++++++
 tb/tb_fwrisc_exec_branch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwrisc_exec_branch_unit_pkg.sv
// Shared encodings for the exec-stage branch unit: op-type/compare codes and
// the branch FSM state type.
package fwrisc_exec_branch_unit_pkg;

    localparam logic [4:0] OP_TYPE_BRANCH = 5'd4;

    localparam logic [5:0] OP_EQ  = 6'd0;
    localparam logic [5:0] OP_NE  = 6'd1;
    localparam logic [5:0] OP_LT  = 6'd2;
    localparam logic [5:0] OP_GE  = 6'd3;
    localparam logic [5:0] OP_LTU = 6'd4;
    localparam logic [5:0] OP_GEU = 6'd5;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_EVAL,
        BR_DONE
    } br_state_e;

    function automatic logic [31:0] instr_len(input logic instr_c);
        return instr_c ? 32'd2 : 32'd4;
    endfunction

endpackage

// File: rtl/fwrisc_exec_branch_unit_if.sv
// Decode-to-exec branch handshake: decoded operands in, PC/completion out.
interface fwrisc_exec_branch_unit_if;
    logic        decode_valid;
    logic        instr_c;
    logic [4:0]  op_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [5:0]  op;
    logic [31:0] op_c;
    logic [5:0]  rd;
    logic [31:0] pc;
    logic        instr_complete;
    logic        branch_taken;
    logic        misalign_exc;
    logic [31:0] exc_tval;

    modport master (
        output decode_valid, instr_c, op_type, op_a, op_b, op, op_c, rd,
        input  pc, instr_complete, branch_taken, misalign_exc, exc_tval
    );

    modport slave (
        input  decode_valid, instr_c, op_type, op_a, op_b, op, op_c, rd,
        output pc, instr_complete, branch_taken, misalign_exc, exc_tval
    );
endinterface

// File: rtl/fwrisc_branch_cond.sv
// Branch compare evaluation; kept standalone so the formal checker can reuse it.
module fwrisc_branch_cond
    import fwrisc_exec_branch_unit_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        cond
);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        cond = 1'b0;
        case (op)
            OP_EQ:   cond = (a == b);
            OP_NE:   cond = (a != b);
            OP_LT:   cond = (a_s < b_s);
            OP_GE:   cond = !(a_s < b_s);
            OP_LTU:  cond = (a < b);
            OP_GEU:  cond = !(a < b);
            default: cond = 1'b0;
        endcase
    end
endmodule

// File: rtl/fwrisc_exec_branch_unit.sv
// Exec-stage branch/PC-update path: capture in IDLE, evaluate in EVAL,
// present the result with a one-cycle instr_complete in DONE.
module fwrisc_exec_branch_unit
    import fwrisc_exec_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC          = 32'h8000_0000,
    parameter bit          ENABLE_COMPRESSED = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    fwrisc_exec_branch_unit_if.slave   br
);
    br_state_e   state;
    br_state_e   next_state;

    logic [31:0] op_a_p0;
    logic [31:0] op_b_p0;
    logic [5:0]  op_p0;
    logic [31:0] op_c_p0;
    logic        instr_c_p0;
    logic [4:0]  op_type_p0;

    logic        cond;
    logic        is_branch;
    logic        mis;
    logic [31:0] target;
    logic [31:0] seq;

    logic [31:0] pc_p1;
    logic        instr_complete_p1;
    logic        branch_taken_p1;
    logic        misalign_exc_p1;
    logic [31:0] exc_tval_p1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BR_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            BR_IDLE: if (br.decode_valid) next_state = BR_EVAL;
            BR_EVAL: next_state = BR_DONE;
            BR_DONE: next_state = BR_IDLE;
            default: next_state = BR_IDLE;
        endcase
    end

    // Stage p0: operand capture; later input changes are ignored until IDLE.
    always_ff @(posedge clock) begin
        if (state == BR_IDLE && br.decode_valid) begin
            op_a_p0    <= br.op_a;
            op_b_p0    <= br.op_b;
            op_p0      <= br.op;
            op_c_p0    <= br.op_c;
            instr_c_p0 <= br.instr_c;
            op_type_p0 <= br.op_type;
        end
    end

    fwrisc_branch_cond u_cond (
        .op   (op_p0),
        .a    (op_a_p0),
        .b    (op_b_p0),
        .cond (cond)
    );

    assign is_branch = (op_type_p0 == OP_TYPE_BRANCH);
    assign target    = pc_p1 + op_c_p0;
    assign seq       = pc_p1 + instr_len(instr_c_p0);
    assign mis       = cond && (target[0] || (!ENABLE_COMPRESSED && target[1]));

    // Stage p1: result registered on EVAL exit; flags live only in DONE.
    // Non-branch op types still complete so every accepted instruction retires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_p1             <= RESET_PC;
            instr_complete_p1 <= 1'b0;
            branch_taken_p1   <= 1'b0;
            misalign_exc_p1   <= 1'b0;
            exc_tval_p1       <= 32'h0;
        end else begin
            instr_complete_p1 <= 1'b0;
            branch_taken_p1   <= 1'b0;
            misalign_exc_p1   <= 1'b0;
            if (state == BR_EVAL) begin
                instr_complete_p1 <= 1'b1;
                if (!is_branch) begin
                    pc_p1 <= seq;
                end else if (mis) begin
                    misalign_exc_p1 <= 1'b1;
                    exc_tval_p1     <= target;
                end else begin
                    pc_p1           <= cond ? target : seq;
                    branch_taken_p1 <= cond;
                end
            end
        end
    end

    assign br.pc             = pc_p1;
    assign br.instr_complete = instr_complete_p1;
    assign br.branch_taken   = branch_taken_p1;
    assign br.misalign_exc   = misalign_exc_p1;
    assign br.exc_tval       = exc_tval_p1;
endmodule

// File: tb/tb_fwrisc_exec_branch_unit.sv
// Bench for fwrisc_exec_branch_unit: two instances (compressed enabled/disabled)
// fed the same instruction stream, each tracked by its own reference PC model.
module tb_fwrisc_exec_branch_unit;
    import fwrisc_exec_branch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        decode_valid = 1'b0;
    logic        instr_c = 1'b0;
    logic [4:0]  op_type = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [5:0]  op = '0;
    logic [31:0] op_c = '0;
    logic [5:0]  rd = '0;

    fwrisc_exec_branch_unit_if if_c ();
    fwrisc_exec_branch_unit_if if_n ();

    assign if_c.decode_valid = decode_valid;
    assign if_c.instr_c      = instr_c;
    assign if_c.op_type      = op_type;
    assign if_c.op_a         = op_a;
    assign if_c.op_b         = op_b;
    assign if_c.op           = op;
    assign if_c.op_c         = op_c;
    assign if_c.rd           = rd;
    assign if_n.decode_valid = decode_valid;
    assign if_n.instr_c      = instr_c;
    assign if_n.op_type      = op_type;
    assign if_n.op_a         = op_a;
    assign if_n.op_b         = op_b;
    assign if_n.op           = op;
    assign if_n.op_c         = op_c;
    assign if_n.rd           = rd;

    fwrisc_exec_branch_unit #(.RESET_PC(RESET_PC), .ENABLE_COMPRESSED(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .br    (if_c)
    );

    fwrisc_exec_branch_unit #(.RESET_PC(RESET_PC), .ENABLE_COMPRESSED(1'b0)) dut_nc (
        .clock (clock),
        .reset (reset),
        .br    (if_n)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses_c = 0;
    int pulses_n = 0;

    always @(negedge clock) begin
        if (if_c.instr_complete === 1'b1) pulses_c++;
        if (if_n.instr_complete === 1'b1) pulses_n++;
    end

    // Reference model state, index 0 = compressed enabled, 1 = disabled.
    logic [31:0] m_pc[2];
    logic        m_tk[2];
    logic        m_mis[2];
    logic [31:0] m_tval[2];

    // Observed values at completion (o_*) and one cycle later (p_*).
    int          lat;
    logic [31:0] o_pc[2];
    logic        o_tk[2];
    logic        o_mis[2];
    logic [31:0] o_tval[2];
    logic        p_ic[2];
    logic        p_tk[2];
    logic        p_mis[2];
    logic [31:0] p_tval[2];

    function automatic logic cond_of(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            OP_EQ:   return a == b;
            OP_NE:   return a != b;
            OP_LT:   return $signed(a) < $signed(b);
            OP_GE:   return $signed(a) >= $signed(b);
            OP_LTU:  return a < b;
            OP_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = RESET_PC; m_tk[i] = 1'b0; m_mis[i] = 1'b0; m_tval[i] = 32'h0;
        end
    endtask

    task automatic model_step(input int i, input logic [4:0] t, input logic [5:0] o,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic ic);
        logic [31:0] target;
        logic [31:0] seq;
        logic        cnd;
        logic        bad;
        target = m_pc[i] + c;
        seq    = m_pc[i] + (ic ? 32'd2 : 32'd4);
        m_tk[i]  = 1'b0;
        m_mis[i] = 1'b0;
        if (t != OP_TYPE_BRANCH) begin
            m_pc[i] = seq;
        end else begin
            cnd = cond_of(o, a, b);
            bad = cnd && ((i == 0) ? (target % 2 != 0) : (target % 4 != 0));
            if (bad) begin
                m_mis[i]  = 1'b1;
                m_tval[i] = target;
            end else begin
                m_pc[i] = cnd ? target : seq;
                m_tk[i] = cnd;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        decode_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
    endtask

    // Issue one instruction from IDLE; the decoder drops valid on completion.
    task automatic issue(input logic [4:0] t, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic ic,
                         input logic scramble);
        op_type = t; op = o; op_a = a; op_b = b; op_c = c; instr_c = ic;
        rd = 6'($urandom_range(0, 63));
        decode_valid = 1'b1;
        model_step(0, t, o, a, b, c, ic);
        model_step(1, t, o, a, b, c, ic);
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            if (k == 1 && scramble) begin
                op_a = $urandom; op_b = $urandom; op_c = $urandom;
                op = 6'($urandom_range(0, 7)); instr_c = ~instr_c;
            end
            if (if_c.instr_complete === 1'b1 && if_n.instr_complete === 1'b1) begin
                lat = k;
                break;
            end
        end
        decode_valid = 1'b0;
        o_pc[0] = if_c.pc; o_tk[0] = if_c.branch_taken; o_mis[0] = if_c.misalign_exc; o_tval[0] = if_c.exc_tval;
        o_pc[1] = if_n.pc; o_tk[1] = if_n.branch_taken; o_mis[1] = if_n.misalign_exc; o_tval[1] = if_n.exc_tval;
        @(posedge clock); #1;
        p_ic[0] = if_c.instr_complete; p_tk[0] = if_c.branch_taken; p_mis[0] = if_c.misalign_exc; p_tval[0] = if_c.exc_tval;
        p_ic[1] = if_n.instr_complete; p_tk[1] = if_n.branch_taken; p_mis[1] = if_n.misalign_exc; p_tval[1] = if_n.exc_tval;
    endtask

    task automatic set_pc(input logic [31:0] val);
        apply_reset();
        issue(OP_TYPE_BRANCH, OP_EQ, 32'h0, 32'h0, val - RESET_PC, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++;
        if (if_c.pc !== RESET_PC || if_n.pc !== RESET_PC) begin
            n_fail++; $display("FAIL reset_pc: got %h/%h want %h", if_c.pc, if_n.pc, RESET_PC);
        end
        n_cmp++;
        if ({if_c.instr_complete, if_c.branch_taken, if_c.misalign_exc,
             if_n.instr_complete, if_n.branch_taken, if_n.misalign_exc} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b%b%b %b%b%b want all 0",
                if_c.instr_complete, if_c.branch_taken, if_c.misalign_exc,
                if_n.instr_complete, if_n.branch_taken, if_n.misalign_exc);
        end
        n_cmp++;
        if (if_c.exc_tval !== 32'h0 || if_n.exc_tval !== 32'h0) begin
            n_fail++; $display("FAIL reset_tval: got %h/%h want 0", if_c.exc_tval, if_n.exc_tval);
        end
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_eq_taken();
        issue(OP_TYPE_BRANCH, OP_EQ, 32'h1234, 32'h1234, 32'h40, 1'b0, 1'b0);
        n_cmp++;
        if (lat != 2) begin n_fail++; $display("FAIL eq_latency: got %0d want 2", lat); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_pc[i] !== 32'h8000_0040 || o_tk[i] !== 1'b1) begin
                n_fail++; $display("FAIL eq_taken[%0d]: pc %h taken %b want 80000040 1", i, o_pc[i], o_tk[i]);
            end
            n_cmp++;
            if (p_ic[i] !== 1'b0 || p_tk[i] !== 1'b0) begin
                n_fail++; $display("FAIL eq_pulse_width[%0d]: next ic %b taken %b want 0 0", i, p_ic[i], p_tk[i]);
            end
        end
    endtask

    task automatic test_signed_boundary();
        apply_reset();
        issue(OP_TYPE_BRANCH, OP_LT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h10, 1'b0, 1'b0);
        n_cmp++;
        if (o_pc[0] !== 32'h8000_0004 || o_tk[0] !== 1'b0) begin
            n_fail++; $display("FAIL lt_signed: pc %h taken %b want 80000004 0", o_pc[0], o_tk[0]);
        end
        apply_reset();
        issue(OP_TYPE_BRANCH, OP_LTU, 32'h7FFF_FFFF, 32'h8000_0000, 32'h10, 1'b0, 1'b0);
        n_cmp++;
        if (o_pc[0] !== 32'h8000_0010 || o_tk[0] !== 1'b1) begin
            n_fail++; $display("FAIL ltu_unsigned: pc %h taken %b want 80000010 1", o_pc[0], o_tk[0]);
        end
    endtask

    task automatic test_compressed_fallthrough();
        set_pc(32'h100);
        issue(OP_TYPE_BRANCH, OP_NE, 32'd5, 32'd5, 32'h40, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_pc[i] !== 32'h102 || o_tk[i] !== 1'b0) begin
                n_fail++; $display("FAIL c_fallthrough[%0d]: pc %h taken %b want 00000102 0", i, o_pc[i], o_tk[i]);
            end
        end
    endtask

    task automatic test_misalign();
        set_pc(32'h100);
        issue(OP_TYPE_BRANCH, OP_EQ, 32'h9, 32'h9, 32'h6, 1'b0, 1'b0);
        n_cmp++;
        if (o_mis[1] !== 1'b1 || o_tval[1] !== 32'h106 || o_pc[1] !== 32'h100 || o_tk[1] !== 1'b0) begin
            n_fail++; $display("FAIL misalign_nc: mis %b tval %h pc %h taken %b want 1 00000106 00000100 0",
                o_mis[1], o_tval[1], o_pc[1], o_tk[1]);
        end
        n_cmp++;
        if (o_mis[0] !== 1'b0 || o_pc[0] !== 32'h106 || o_tk[0] !== 1'b1) begin
            n_fail++; $display("FAIL align_c: mis %b pc %h taken %b want 0 00000106 1", o_mis[0], o_pc[0], o_tk[0]);
        end
        n_cmp++;
        if (p_mis[1] !== 1'b0 || p_tval[1] !== 32'h106) begin
            n_fail++; $display("FAIL misalign_after: mis %b tval %h want 0 00000106", p_mis[1], p_tval[1]);
        end
        issue(OP_TYPE_BRANCH, OP_NE, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
        n_cmp++;
        if (o_mis[0] !== 1'b1 || o_tval[0] !== 32'h109 || o_pc[0] !== 32'h106) begin
            n_fail++; $display("FAIL misalign_odd_c: mis %b tval %h pc %h want 1 00000109 00000106",
                o_mis[0], o_tval[0], o_pc[0]);
        end
    endtask

    task automatic test_self_loop_and_wrap();
        set_pc(32'hFFFF_FFFC);
        issue(OP_TYPE_BRANCH, OP_GEU, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_pc[0] !== 32'hFFFF_FFFC || o_tk[0] !== 1'b1) begin
            n_fail++; $display("FAIL self_loop: pc %h taken %b want fffffffc 1", o_pc[0], o_tk[0]);
        end
        issue(OP_TYPE_BRANCH, OP_GE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_pc[i] !== 32'h0000_0004 || o_tk[i] !== 1'b1) begin
                n_fail++; $display("FAIL wrap[%0d]: pc %h taken %b want 00000004 1", i, o_pc[i], o_tk[i]);
            end
        end
        issue(5'd1, OP_EQ, 32'h1, 32'h1, 32'h40, 1'b1, 1'b0);
        n_cmp++;
        if (lat != 2 || o_pc[0] !== 32'h6 || o_tk[0] !== 1'b0) begin
            n_fail++; $display("FAIL non_branch: lat %0d pc %h taken %b want 2 00000006 0", lat, o_pc[0], o_tk[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        int base;
        apply_reset();
        op_type = OP_TYPE_BRANCH; op = OP_EQ; op_a = 32'h7; op_b = 32'h7; op_c = 32'h40; instr_c = 1'b0;
        decode_valid = 1'b1;
        @(posedge clock); #1;
        base = pulses_c + pulses_n;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (if_c.pc !== RESET_PC || if_n.pc !== RESET_PC || if_c.instr_complete !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_state: pc %h/%h ic %b want %h 0", if_c.pc, if_n.pc, if_c.instr_complete, RESET_PC);
        end
        decode_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (pulses_c + pulses_n != base) begin
            n_fail++; $display("FAIL mid_reset_no_complete: pulses %0d want %0d", pulses_c + pulses_n, base);
        end
        reset = 1'b1;
        model_reset();
        issue(OP_TYPE_BRANCH, OP_EQ, 32'h3, 32'h3, 32'h20, 1'b0, 1'b0);
        n_cmp++;
        if (lat != 2 || o_pc[0] !== 32'h8000_0020) begin
            n_fail++; $display("FAIL after_reset_issue: lat %0d pc %h want 2 80000020", lat, o_pc[0]);
        end
    endtask

    task automatic test_back_to_back();
        int base_c;
        int base_n;
        logic [4:0]  t;
        logic [5:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        apply_reset();
        base_c = pulses_c;
        base_n = pulses_n;
        for (int n = 0; n < 100; n++) begin
            t = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : OP_TYPE_BRANCH;
            o = 6'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = a;
                1: b = $urandom;
                default: b = a ^ (32'h1 << $urandom_range(0, 31));
            endcase
            c = 32'(int'($urandom_range(0, 8191)) - 4096);
            issue(t, o, a, b, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (lat != 2) begin n_fail++; $display("FAIL rnd_latency #%0d: got %0d want 2", n, lat); end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (o_pc[i] !== m_pc[i] || o_tk[i] !== m_tk[i] || o_mis[i] !== m_mis[i]) begin
                    n_fail++; $display("FAIL rnd_result #%0d[%0d]: pc %h tk %b mis %b want %h %b %b",
                        n, i, o_pc[i], o_tk[i], o_mis[i], m_pc[i], m_tk[i], m_mis[i]);
                end
                if (m_mis[i]) begin
                    n_cmp++;
                    if (o_tval[i] !== m_tval[i]) begin
                        n_fail++; $display("FAIL rnd_tval #%0d[%0d]: got %h want %h", n, i, o_tval[i], m_tval[i]);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses_c - base_c != 100 || pulses_n - base_n != 100) begin
            n_fail++; $display("FAIL rnd_pulse_count: got %0d/%0d want 100", pulses_c - base_c, pulses_n - base_n);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_eq_taken();
        test_signed_boundary();
        test_compressed_fallthrough();
        test_misalign();
        test_self_loop_and_wrap();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
